// File: rtl/clock_mon_defs.sv
// Shared definitions for the clock edge monitor: FSM state encoding and
// default sizing constants used by the top level and its sub-blocks.
package clock_mon_defs;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT1   = 2'd1,
        ST_MEASURE = 2'd2,
        ST_TRACK   = 2'd3
    } mon_state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_LOCK_COUNT  = 4;
    localparam int DEF_TOL         = 1;

    // Lock counter width; LOCK_COUNT is limited to 1..15 so four bits suffice.
    localparam int LOCK_W = 4;

endpackage

// File: rtl/sync_edge_detect.sv
// Brings an asynchronous level into the CLK_I domain through a flop chain and
// decodes rising/falling transitions of the synchronised level.
module sync_edge_detect
    import clock_mon_defs::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic CLK_I,
    input  logic RST_I,
    input  logic D_I,
    output logic LVL_O,
    output logic RISE_O,
    output logic FALL_O
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_d;

    // The chain always samples; gating of the edge pulses is left to the consumer.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            sync_q  <= '0;
            level_d <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], D_I};
            level_d <= sync_q[SYNC_STAGES-1];
        end
    end

    assign LVL_O  = sync_q[SYNC_STAGES-1];
    assign RISE_O = sync_q[SYNC_STAGES-1] & ~level_d;
    assign FALL_O = ~sync_q[SYNC_STAGES-1] & level_d;

endmodule

// File: rtl/clock_edge_monitor.sv
// Monitors a slow clock or strobe: single-cycle edge pulses, rise-to-rise
// period measurement, frequency lock indication and loss-of-clock timeout.
module clock_edge_monitor
    import clock_mon_defs::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int LOCK_COUNT  = DEF_LOCK_COUNT,
    parameter int TOL         = DEF_TOL
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic             SLOW_I,
    input  logic             EN_I,
    output logic             RISE_O,
    output logic             FALL_O,
    output logic [CNT_W-1:0] PERIOD_O,
    output logic             PERIOD_VLD_O,
    output logic             LOCKED_O,
    output logic             TIMEOUT_O
);

    localparam int                DIFF_W      = CNT_W + 1;
    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
    localparam logic [DIFF_W-1:0] TOL_V       = DIFF_W'(TOL);
    localparam logic [LOCK_W-1:0] LOCK_TARGET = LOCK_W'(LOCK_COUNT);
    localparam logic [LOCK_W-1:0] LOCK_ONE    = LOCK_W'(1);

    mon_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [LOCK_W-1:0] lock_cnt;
    logic              level;
    logic              rise;
    logic              fall;
    logic [DIFF_W-1:0] diff;
    logic              in_tol;
    logic              cnt_sat;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .CLK_I (CLK_I),
        .RST_I (RST_I),
        .D_I   (SLOW_I),
        .LVL_O (level),
        .RISE_O(rise),
        .FALL_O(fall)
    );

    // Absolute period difference, one bit wider so the subtraction never wraps.
    always_comb begin
        diff = '0;
        if (cnt >= PERIOD_O) begin
            diff = {1'b0, cnt} - {1'b0, PERIOD_O};
        end else begin
            diff = {1'b0, PERIOD_O} - {1'b0, cnt};
        end
    end

    assign in_tol  = (diff <= TOL_V);
    assign cnt_sat = (cnt == CNT_MAX);

    // Single FSM owning the counter, lock tracking and every registered output.
    // A rise seen together with counter saturation is processed as a normal
    // rise, so the saturated value is reported instead of a timeout.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            lock_cnt     <= '0;
            PERIOD_O     <= '0;
            RISE_O       <= 1'b0;
            FALL_O       <= 1'b0;
            PERIOD_VLD_O <= 1'b0;
            LOCKED_O     <= 1'b0;
            TIMEOUT_O    <= 1'b0;
        end else if (!EN_I) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            lock_cnt     <= '0;
            RISE_O       <= 1'b0;
            FALL_O       <= 1'b0;
            PERIOD_VLD_O <= 1'b0;
            LOCKED_O     <= 1'b0;
            TIMEOUT_O    <= 1'b0;
        end else begin
            RISE_O       <= (state != ST_IDLE) && rise;
            FALL_O       <= (state != ST_IDLE) && fall;
            PERIOD_VLD_O <= 1'b0;
            if ((state != ST_IDLE) && rise) begin
                TIMEOUT_O <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    state <= ST_WAIT1;
                    cnt   <= '0;
                end

                ST_WAIT1: begin
                    if (rise) begin
                        state <= ST_MEASURE;
                        cnt   <= CNT_ONE;
                    end
                end

                ST_MEASURE: begin
                    if (rise) begin
                        PERIOD_O     <= cnt;
                        PERIOD_VLD_O <= 1'b1;
                        cnt          <= CNT_ONE;
                        lock_cnt     <= '0;
                        state        <= ST_TRACK;
                    end else if (cnt_sat) begin
                        TIMEOUT_O <= 1'b1;
                        LOCKED_O  <= 1'b0;
                        lock_cnt  <= '0;
                        cnt       <= '0;
                        state     <= ST_WAIT1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                ST_TRACK: begin
                    if (lock_cnt == LOCK_TARGET) begin
                        LOCKED_O <= 1'b1;
                    end
                    if (rise) begin
                        PERIOD_O     <= cnt;
                        PERIOD_VLD_O <= 1'b1;
                        cnt          <= CNT_ONE;
                        if (in_tol) begin
                            if (lock_cnt != LOCK_TARGET) begin
                                lock_cnt <= lock_cnt + LOCK_ONE;
                            end
                        end else begin
                            lock_cnt <= '0;
                            LOCKED_O <= 1'b0;
                        end
                    end else if (cnt_sat) begin
                        TIMEOUT_O <= 1'b1;
                        LOCKED_O  <= 1'b0;
                        lock_cnt  <= '0;
                        cnt       <= '0;
                        state     <= ST_WAIT1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
            endcase
        end
    end

    // A decoded rise implies the synchronised level is high; a period update
    // always coincides with its rise pulse.
    assert property (@(posedge CLK_I) disable iff (RST_I) rise |-> level);
    assert property (@(posedge CLK_I) disable iff (RST_I) PERIOD_VLD_O |-> RISE_O);

endmodule

// File: tb/tb_clock_edge_monitor.sv
// Directed bench: default-sized monitor for edges, period, lock, enable and
// reset; a 6-bit-counter instance for timeout and saturation corner cases.
module tb_clock_edge_monitor;

    logic        clk;
    logic        rst;
    logic        slow;
    logic        en;
    logic        en6;

    logic        rise;
    logic        fall;
    logic [15:0] period;
    logic        periodVld;
    logic        locked;
    logic        timeout;

    logic        rise6;
    logic        fall6;
    logic [5:0]  period6;
    logic        periodVld6;
    logic        locked6;
    logic        timeout6;

    int checkCount = 0;
    int failCount  = 0;
    int cyc        = 0;

    int          riseCount = 0;
    int          fallCount = 0;
    int          vldCount  = 0;
    int          vldNoRise = 0;
    int          lastRiseCycle = 0;
    int          lastFallCycle = 0;
    int          lastVldCycle  = 0;
    int          lockRiseCycle = 0;
    int          riseEdgeCycle = 0;
    int          fallEdgeCycle = 0;
    logic [15:0] lastPeriod    = '0;
    logic        lockedPrev    = 1'b0;
    logic        vldPrevLocked = 1'b0;
    logic        vldLocked     = 1'b0;

    int          vldCount6          = 0;
    int          lastRiseCycle6     = 0;
    int          timeoutHigh6       = 0;
    int          timeoutRiseCycle6  = 0;
    int          timeoutFallCycle6  = 0;
    logic [5:0]  lastPeriod6        = '0;
    logic        timeoutPrev6       = 1'b0;

    int snapA;
    int snapB;

    clock_edge_monitor dut (
        .CLK_I       (clk),
        .RST_I       (rst),
        .SLOW_I      (slow),
        .EN_I        (en),
        .RISE_O      (rise),
        .FALL_O      (fall),
        .PERIOD_O    (period),
        .PERIOD_VLD_O(periodVld),
        .LOCKED_O    (locked),
        .TIMEOUT_O   (timeout)
    );

    clock_edge_monitor #(
        .CNT_W(6)
    ) dut6 (
        .CLK_I       (clk),
        .RST_I       (rst),
        .SLOW_I      (slow),
        .EN_I        (en6),
        .RISE_O      (rise6),
        .FALL_O      (fall6),
        .PERIOD_O    (period6),
        .PERIOD_VLD_O(periodVld6),
        .LOCKED_O    (locked6),
        .TIMEOUT_O   (timeout6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Advance one clock and log output events, sampled just after the edge.
    task automatic cycleStep();
        @(posedge clk);
        #1;
        cyc++;
        if (rise) begin
            riseCount++;
            lastRiseCycle = cyc;
        end
        if (fall) begin
            fallCount++;
            lastFallCycle = cyc;
        end
        if (periodVld) begin
            vldCount++;
            lastPeriod    = period;
            lastVldCycle  = cyc;
            vldPrevLocked = lockedPrev;
            vldLocked     = locked;
            if (!rise) vldNoRise++;
        end
        if (locked && !lockedPrev) lockRiseCycle = cyc;
        lockedPrev = locked;

        if (rise6) lastRiseCycle6 = cyc;
        if (periodVld6) begin
            vldCount6++;
            lastPeriod6 = period6;
        end
        if (timeout6) timeoutHigh6++;
        if (timeout6 && !timeoutPrev6) timeoutRiseCycle6 = cyc;
        if (!timeout6 && timeoutPrev6) timeoutFallCycle6 = cyc;
        timeoutPrev6 = timeout6;
    endtask

    // One slow-clock period: high for highCycles, then low for lowCycles.
    task automatic applyStimulus(input int highCycles, input int lowCycles);
        slow = 1'b1;
        riseEdgeCycle = cyc;
        repeat (highCycles) cycleStep();
        slow = 1'b0;
        fallEdgeCycle = cyc;
        repeat (lowCycles) cycleStep();
    endtask

    initial begin
        rst  = 1'b1;
        slow = 1'b0;
        en   = 1'b0;
        en6  = 1'b0;
        repeat (3) cycleStep();
        checkOutput("rst_rise",    32'(rise), 32'd0);
        checkOutput("rst_fall",    32'(fall), 32'd0);
        checkOutput("rst_period",  32'(period), 32'd0);
        checkOutput("rst_vld",     32'(periodVld), 32'd0);
        checkOutput("rst_locked",  32'(locked), 32'd0);
        checkOutput("rst_timeout", 32'(timeout), 32'd0);
        rst = 1'b0;
        cycleStep();

        $display("[TB] 10/10 slow clock, lock acquisition");
        en = 1'b1;
        cycleStep();
        applyStimulus(10, 10);
        checkOutput("t1_rise_latency", 32'(lastRiseCycle - riseEdgeCycle), 32'd3);
        checkOutput("t1_fall_latency", 32'(lastFallCycle - fallEdgeCycle), 32'd3);
        checkOutput("t1_no_vld_first", 32'(vldCount), 32'd0);
        repeat (5) applyStimulus(10, 10);
        checkOutput("t1_rise_count",   32'(riseCount), 32'd6);
        checkOutput("t1_fall_count",   32'(fallCount), 32'd6);
        checkOutput("t1_vld_count",    32'(vldCount), 32'd5);
        checkOutput("t1_period",       32'(lastPeriod), 32'd20);
        checkOutput("t1_unlocked_vld", 32'(vldLocked), 32'd0);
        checkOutput("t1_locked",       32'(locked), 32'd1);
        checkOutput("t1_lock_delay",   32'(lockRiseCycle - lastVldCycle), 32'd1);

        $display("[TB] period step to 22, relock, tolerance edge");
        applyStimulus(11, 11);
        checkOutput("t2_period_20",   32'(lastPeriod), 32'd20);
        checkOutput("t2_still_lock",  32'(vldLocked), 32'd1);
        applyStimulus(11, 11);
        checkOutput("t2_period_22",   32'(lastPeriod), 32'd22);
        checkOutput("t2_lock_before", 32'(vldPrevLocked), 32'd1);
        checkOutput("t2_lock_drop",   32'(vldLocked), 32'd0);
        repeat (3) applyStimulus(11, 11);
        checkOutput("t2_not_yet",     32'(locked), 32'd0);
        applyStimulus(11, 11);
        checkOutput("t2_relocked",    32'(locked), 32'd1);
        applyStimulus(10, 11);
        applyStimulus(11, 11);
        checkOutput("t2_period_21",   32'(lastPeriod), 32'd21);
        checkOutput("t2_tol_lock",    32'(vldLocked), 32'd1);
        checkOutput("t2_vld_rise",    32'(vldNoRise), 32'd0);

        $display("[TB] enable dropped while locked");
        en = 1'b0;
        cycleStep();
        checkOutput("t6_locked", 32'(locked), 32'd0);
        checkOutput("t6_vld",    32'(periodVld), 32'd0);
        checkOutput("t6_period", 32'(period), 32'd21);
        snapA = riseCount;
        snapB = vldCount;
        applyStimulus(10, 10);
        checkOutput("t6_no_rise",  32'(riseCount), 32'(snapA));
        checkOutput("t6_no_vld",   32'(vldCount), 32'(snapB));
        checkOutput("t6_held",     32'(period), 32'd21);
        en = 1'b1;
        cycleStep();
        applyStimulus(10, 10);
        checkOutput("t6_wait1",    32'(vldCount), 32'(snapB));
        applyStimulus(10, 10);
        checkOutput("t6_restart",  32'(vldCount), 32'(snapB + 1));
        checkOutput("t6_period20", 32'(lastPeriod), 32'd20);

        $display("[TB] reset pulse mid-period");
        slow = 1'b1;
        repeat (10) cycleStep();
        slow = 1'b0;
        repeat (4) cycleStep();
        rst = 1'b1;
        cycleStep();
        checkOutput("t5_rise",    32'(rise), 32'd0);
        checkOutput("t5_period",  32'(period), 32'd0);
        checkOutput("t5_vld",     32'(periodVld), 32'd0);
        checkOutput("t5_locked",  32'(locked), 32'd0);
        rst = 1'b0;
        repeat (6) cycleStep();
        snapB = vldCount;
        applyStimulus(10, 10);
        checkOutput("t5_first_rise",  32'(vldCount), 32'(snapB));
        applyStimulus(10, 10);
        checkOutput("t5_second_rise", 32'(vldCount), 32'(snapB + 1));
        checkOutput("t5_period20",    32'(lastPeriod), 32'd20);

        $display("[TB] 6-bit counter: loss of clock");
        en  = 1'b0;
        en6 = 1'b1;
        cycleStep();
        repeat (6) applyStimulus(10, 10);
        checkOutput("t3_period20", 32'(lastPeriod6), 32'd20);
        checkOutput("t3_locked",   32'(locked6), 32'd1);
        for (int i = 0; i < 100 && !timeout6; i++) cycleStep();
        checkOutput("t3_timeout",       32'(timeout6), 32'd1);
        checkOutput("t3_lock_lost",     32'(locked6), 32'd0);
        checkOutput("t3_timeout_delay", 32'(timeoutRiseCycle6 - lastRiseCycle6), 32'd63);
        snapA = vldCount6;
        applyStimulus(10, 10);
        checkOutput("t3_cleared",   32'(timeout6), 32'd0);
        checkOutput("t3_clear_at",  32'(timeoutFallCycle6), 32'(lastRiseCycle6));
        checkOutput("t3_wait1",     32'(vldCount6), 32'(snapA));

        $display("[TB] 6-bit counter: rise on saturation");
        snapB = timeoutHigh6;
        applyStimulus(31, 32);
        checkOutput("t4_period20", 32'(lastPeriod6), 32'd20);
        applyStimulus(10, 10);
        checkOutput("t4_period63",  32'(lastPeriod6), 32'd63);
        checkOutput("t4_vld_count", 32'(vldCount6), 32'(snapA + 2));
        checkOutput("t4_no_timeout", 32'(timeoutHigh6), 32'(snapB));

        $display("test done: total=%0d bad=%0d", checkCount, failCount);
        $finish;
    end

endmodule
